alu_share_arbiter: RTL and testbench

//  Shares one 32-bit ALU datapath between two requesters (e.g. fetch/address unit and execute unit).
//  - Round-robin arbitration between requesters; valid/ready handshake on each request port.
//  - Drives the ALU operands and opcode, waits the ALU latency, then captures the result.
//  - Returns the result on a single valid/ready response channel, tagged with the requester ID.
//  - Sits between the requester front-ends and the combinational/pipelined ALU top level.

---
 rtl/alu_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU datapath between two requesters, with a single tagged response channel.
// Optional grant counters (gnt_cnt0/gnt_cnt1) are built when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [OPW-1:0]   r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [OPW-1:0]   r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1,
`endif
  output logic [1:0]       dbg_state
);

  if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
    $error("alu_share_arbiter: ALU_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

  state_e           state_q;
  logic             last_grant_q;
  logic [3:0]       lat_cnt_q;
  logic [OPW-1:0]   alu_op_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic grant_vld;
  logic grant_id;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // sender holds its payload stable while valid is high and ready is low.
  always_comb begin
    grant_vld = r0_valid | r1_valid;
    grant_id  = r1_valid;
    if (r0_valid && r1_valid) grant_id = ~last_grant_q;
  end

  assign r0_ready = (state_q == IDLE) && grant_vld && !grant_id;
  assign r1_ready = (state_q == IDLE) && grant_vld &&  grant_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      lat_cnt_q    <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            alu_op_q     <= grant_id ? r1_op : r0_op;
            alu_a_q      <= grant_id ? r1_a  : r0_a;
            alu_b_q      <= grant_id ? r1_b  : r0_b;
            last_grant_q <= grant_id;
            rsp_id_q     <= grant_id;
            lat_cnt_q    <= LAT_INIT;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          // Operands stay driven for the whole wait; the ALU result is sampled once.
          if (lat_cnt_q == 4'd0) begin
            rsp_data_q  <= alu_result;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign dbg_state = state_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] gnt_cnt0_q;
  logic [15:0] gnt_cnt1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      if (r0_valid && r0_ready && gnt_cnt0_q != 16'hFFFF) gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
      if (r1_valid && r1_ready && gnt_cnt1_q != 16'hFFFF) gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: instance 0 uses ALU_LAT=1, instance 1 uses ALU_LAT=4.
// Grant table, hand-written corner sequences, then randomized traffic against a transaction model.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        r0_valid[2], r0_ready[2], r1_valid[2], r1_ready[2];
  logic [2:0]  r0_op[2], r1_op[2], alu_op[2];
  logic [31:0] r0_a[2], r0_b[2], r1_a[2], r1_b[2];
  logic [31:0] alu_a[2], alu_b[2], alu_result[2], rsp_data[2];
  logic        rsp_valid[2], rsp_ready[2], rsp_id[2];
  logic [1:0]  dbg_state[2];
`ifdef ALU_ARB_STATS_EN
  logic [15:0] gnt_cnt0[2], gnt_cnt1[2];
`endif

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];  // {instance, requester id, expected data}

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a ^ b;
      3'd1:    return a + b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return a - b;
    endcase
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int LAT = (g == 0) ? 1 : 4;
    alu_share_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .r0_valid(r0_valid[g]), .r0_ready(r0_ready[g]), .r0_op(r0_op[g]), .r0_a(r0_a[g]), .r0_b(r0_b[g]),
      .r1_valid(r1_valid[g]), .r1_ready(r1_ready[g]), .r1_op(r1_op[g]), .r1_a(r1_a[g]), .r1_b(r1_b[g]),
      .alu_op(alu_op[g]), .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_result(alu_result[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_id(rsp_id[g]), .rsp_data(rsp_data[g]),
`ifdef ALU_ARB_STATS_EN
      .gnt_cnt0(gnt_cnt0[g]), .gnt_cnt1(gnt_cnt1[g]),
`endif
      .dbg_state(dbg_state[g])
    );
    if (LAT == 1) begin : g_comb
      assign alu_result[g] = alu_f(alu_op[g], alu_a[g], alu_b[g]);
    end else begin : g_pipe
      // LAT-1 register stages: the result is only correct when sampled LAT edges after issue.
      logic [31:0] p [LAT-1];
      always @(posedge clk) begin
        p[0] <= alu_f(alu_op[g], alu_a[g], alu_b[g]);
        for (int i = 1; i < LAT - 1; i++) p[i] <= p[i-1];
      end
      assign alu_result[g] = p[LAT-2];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int d, input bit w, input bit v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (!w) begin
      r0_valid[d] = v; r0_op[d] = op; r0_a[d] = a; r0_b[d] = b;
    end else begin
      r1_valid[d] = v; r1_op[d] = op; r1_a[d] = a; r1_b[d] = b;
    end
  endtask

  task automatic clear_all();
    for (int d = 0; d < 2; d++) begin
      set_req(d, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      set_req(d, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
      rsp_ready[d] = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    chk({tag, "_r0_ready"}, r0_ready[d], 0);
    chk({tag, "_r1_ready"}, r1_ready[d], 0);
    chk({tag, "_alu_op"}, alu_op[d], 0);
    chk({tag, "_alu_a"}, alu_a[d], 0);
    chk({tag, "_alu_b"}, alu_b[d], 0);
    chk({tag, "_rsp_valid"}, rsp_valid[d], 0);
    chk({tag, "_rsp_id"}, rsp_id[d], 0);
    chk({tag, "_rsp_data"}, rsp_data[d], 0);
    chk({tag, "_state"}, dbg_state[d], 0);
  endtask

  // One lone-requester transaction: accept, latency, operand hold, response,
  // optional stall in RESP with both requesters pushing, then handshake.
  task automatic hand_txn(input int d, input bit w, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int stall);
    int k;
    bit hold_ok, got, stall_ok;
    logic [31:0] exp_d;
    exp_d = alu_f(op, a, b);
    @(posedge clk); #1;
    set_req(d, w, 1'b1, op, a, b);
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    chk("txn_ready", w ? r1_ready[d] : r0_ready[d], 1);
    @(posedge clk); #1;
    set_req(d, w, 1'b0, op, a, b);
    hold_ok = 1'b1; got = 1'b0; k = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (alu_a[d] !== a || alu_b[d] !== b || alu_op[d] !== op) hold_ok = 1'b0;
      got = rsp_valid[d];
    end
    chk("txn_latency", k, lat_of(d) + 1);
    chk("txn_operand_hold", hold_ok, 1);
    chk("txn_rsp_id", rsp_id[d], w);
    chk("txn_rsp_data", rsp_data[d], exp_d);
    stall_ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      r0_valid[d] = 1'b1;
      r1_valid[d] = 1'b1;
      @(negedge clk);
      if (rsp_valid[d] !== 1'b1 || rsp_id[d] !== w || rsp_data[d] !== exp_d ||
          r0_ready[d] !== 1'b0 || r1_ready[d] !== 1'b0 || dbg_state[d] !== 2'd2) stall_ok = 1'b0;
    end
    if (stall > 0) chk("txn_stall_hold", stall_ok, 1);
    @(posedge clk); #1;
    rsp_ready[d] = 1'b1;
    r0_valid[d] = 1'b0;
    r1_valid[d] = 1'b0;
    @(negedge clk);
    chk("txn_hs_valid", rsp_valid[d], 1);
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    chk("txn_post_hs_valid", rsp_valid[d], 0);
    chk("txn_post_hs_state", dbg_state[d], 0);
    chk("txn_rsp_data_hold", rsp_data[d], exp_d);
  endtask

  function automatic int find_q(input bit d);
    foreach (exp_q[i]) if (exp_q[i][33] == d) return i;
    return -1;
  endfunction

  typedef struct {
    logic v0;
    logic v1;
    logic e0;
    logic e1;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int nacc, guard, idx, lat;
    bit exp_w, w, no_rsp, er0, er1, g, v;
    logic exp_id_q[$];
    bit busy[2], lastg[2], seen[2];
    bit acc_seen[2][2];
    int acc_c[2], m0[2], m1[2];

    // Grant decisions straight after reset (last grant = requester 1).
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0};

    clear_all();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs(0, "rst0");
    check_idle_outputs(1, "rst1");
`ifdef ALU_ARB_STATS_EN
    chk("rst_gnt_cnt0", gnt_cnt0[0], 0);
    chk("rst_gnt_cnt1", gnt_cnt1[0], 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      r0_valid[0] = vecs[i].v0;
      r1_valid[0] = vecs[i].v1;
      @(negedge clk);
      chk($sformatf("grant_vec%0d_r0_ready", i), r0_ready[0], vecs[i].e0);
      chk($sformatf("grant_vec%0d_r1_ready", i), r1_ready[0], vecs[i].e1);
      #1;
      r0_valid[0] = 1'b0;
      r1_valid[0] = 1'b0;
    end
    @(negedge clk);
    chk("grant_vec_state_idle", dbg_state[0], 0);

    // Both requesters valid continuously: grants alternate starting with r0.
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b1, 3'($urandom_range(0, 4)), $urandom, $urandom);
    set_req(0, 1'b1, 1'b1, 3'($urandom_range(0, 4)), $urandom, $urandom);
    rsp_ready[0] = 1'b1;
    nacc = 0; guard = 0; exp_w = 1'b0;
    while (nacc < 4 && guard < 60) begin
      @(negedge clk);
      guard++;
      if (rsp_valid[0] && rsp_ready[0]) begin
        if (exp_id_q.size() == 0) chk("t2_rsp_unexpected", rsp_valid[0], 0);
        else chk("t2_rsp_id", rsp_id[0], exp_id_q.pop_front());
      end
      if (r0_ready[0] || r1_ready[0]) begin
        chk("t2_one_ready", r0_ready[0] & r1_ready[0], 0);
        w = r1_ready[0];
        chk("t2_grant_order", w, exp_w);
        exp_w = ~exp_w;
        nacc++;
        exp_id_q.push_back(w);
        @(posedge clk); #1;
        if (nacc < 4) set_req(0, w, 1'b1, 3'($urandom_range(0, 4)), $urandom, $urandom);
        else begin
          r0_valid[0] = 1'b0;
          r1_valid[0] = 1'b0;
        end
      end
    end
    chk("t2_accepts", nacc, 4);
    guard = 0;
    while (exp_id_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
      if (rsp_valid[0] && rsp_ready[0]) chk("t2_rsp_id", rsp_id[0], exp_id_q.pop_front());
    end
    chk("t2_drained", exp_id_q.size(), 0);
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;

    // Lone r0, XOR, then r1 with a stalled response.
    hand_txn(0, 1'b0, 3'd0, 32'h0000FFFF, 32'h00FF00FF, 0);
    chk("t1_xor_result", rsp_data[0], 32'h00FFFF00);
    hand_txn(0, 1'b1, 3'd1, $urandom, $urandom, 4);

    // Four-cycle ALU.
    hand_txn(1, 1'b1, 3'd2, $urandom, $urandom, 0);
    hand_txn(1, 1'b0, 3'd4, $urandom, $urandom, 2);

    // Reset during EXEC discards the operation and restores r0 priority.
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b1, 3'd1, $urandom, $urandom);
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("t4_accept", r0_ready[1], 1);
    @(posedge clk); #1;
    r0_valid[1] = 1'b0;
    @(negedge clk);
    chk("t4_in_exec", dbg_state[1], 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs(1, "t4");
`ifdef ALU_ARB_STATS_EN
    chk("t4_gnt_cnt0", gnt_cnt0[1], 0);
    chk("t4_gnt_cnt1", gnt_cnt1[1], 0);
`endif
    no_rsp = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b0) no_rsp = 1'b0;
    end
    chk("t4_no_rsp", no_rsp, 1);
    @(posedge clk); #1;
    r0_valid[1] = 1'b1;
    r1_valid[1] = 1'b1;
    @(negedge clk);
    chk("t4_conflict_r0", r0_ready[1], 1);
    chk("t4_conflict_r1", r1_ready[1], 0);
    #1;
    r0_valid[1] = 1'b0;
    r1_valid[1] = 1'b0;

    // Randomized traffic on both instances against a transaction-level model.
    clear_all();
    do_reset(2);
    for (int d = 0; d < 2; d++) begin
      busy[d] = 1'b0; lastg[d] = 1'b1; seen[d] = 1'b0; acc_c[d] = 0; m0[d] = 0; m1[d] = 0;
      acc_seen[d][0] = 1'b0; acc_seen[d][1] = 1'b0;
    end
    for (int c = 0; c < 640; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        for (int wi = 0; wi < 2; wi++) begin
          v = (wi == 0) ? r0_valid[d] : r1_valid[d];
          if (!v || acc_seen[d][wi])
            set_req(d, wi[0], (c < 600) && ($urandom_range(0, 2) != 0),
                    3'($urandom_range(0, 4)), $urandom, $urandom);
        end
        rsp_ready[d] = (c >= 600) || ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        lat = lat_of(d);
        acc_seen[d][0] = r0_valid[d] && r0_ready[d];
        acc_seen[d][1] = r1_valid[d] && r1_ready[d];
        g = (r0_valid[d] && r1_valid[d]) ? ~lastg[d] : r1_valid[d];
        er0 = !busy[d] && (r0_valid[d] || r1_valid[d]) && !g;
        er1 = !busy[d] && (r0_valid[d] || r1_valid[d]) && g;
        chk("rand_ready", {r1_ready[d], r0_ready[d]}, {er1, er0});
        if (er0 || er1) begin
          busy[d] = 1'b1;
          seen[d] = 1'b0;
          lastg[d] = g;
          acc_c[d] = c;
          if (g) begin
            m1[d]++;
            exp_q.push_back({d[0], 1'b1, alu_f(r1_op[d], r1_a[d], r1_b[d])});
          end else begin
            m0[d]++;
            exp_q.push_back({d[0], 1'b0, alu_f(r0_op[d], r0_a[d], r0_b[d])});
          end
        end
        if (!busy[d]) chk("rand_rsp_idle", rsp_valid[d], 0);
        else if (!seen[d]) begin
          if (c - acc_c[d] == lat + 1) begin
            chk("rand_rsp_on_time", rsp_valid[d], 1);
            if (rsp_valid[d] === 1'b1) seen[d] = 1'b1;
            else begin
              idx = find_q(d[0]);
              if (idx >= 0) exp_q.delete(idx);
              busy[d] = 1'b0;
            end
          end else chk("rand_rsp_early", rsp_valid[d], 0);
        end
        if (busy[d] && seen[d]) begin
          idx = find_q(d[0]);
          chk("rand_rsp_held", rsp_valid[d], 1);
          if (idx >= 0) begin
            chk("rand_rsp_id", rsp_id[d], exp_q[idx][32]);
            chk("rand_rsp_data", rsp_data[d], exp_q[idx][31:0]);
            if (rsp_ready[d]) exp_q.delete(idx);
          end
          if (rsp_ready[d]) begin
            busy[d] = 1'b0;
            seen[d] = 1'b0;
          end
        end
      end
    end
    chk("rand_drain", exp_q.size(), 0);
`ifdef ALU_ARB_STATS_EN
    for (int d = 0; d < 2; d++) begin
      chk("rand_gnt_cnt0", gnt_cnt0[d], 16'(m0[d]));
      chk("rand_gnt_cnt1", gnt_cnt1[d], 16'(m1[d]));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
